dmac_bus_arbiter: RTL and testbench
===================================

Name: dmac_bus_arbiter

Overview:
Two-master, two-slave shared-bus arbiter and address decoder for the DMAC subsystem.
- Master 0 is the DMAC master port. Master 1 is the host/CPU-side master.
- Slave 0 is the DMAC slave register file. Slave 1 is the data memory.
- The block grants the bus round-robin, holds the grant while the owner keeps requesting, enforces a starvation limit, and muxes address/write data/read data between owner and selected slave.

Parameters:
MAX_HOLD, 16, max consecutive granted cycles for one owner while the other master is requesting (must be >= 2).
CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 bus request
m0_wr  input  1  master 0 write strobe (1=write, 0=read)
m0_addr  input  16  master 0 address
m0_dout  input  32  master 0 write data
m0_grant  output  1  master 0 owns bus (registered)
m1_req  input  1  master 1 bus request
m1_wr  input  1  master 1 write strobe
m1_addr  input  16  master 1 address
m1_dout  input  32  master 1 write data
m1_grant  output  1  master 1 owns bus (registered)
m_din  output  32  read data returned to both masters
s0_sel  output  1  slave 0 select
s1_sel  output  1  slave 1 select
s_wr  output  1  write strobe to slaves
s_addr  output  16  address to slaves
s_din  output  32  write data to slaves
s0_dout  input  32  slave 0 read data
s1_dout  input  32  slave 1 read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset values:
  - State = IDLE; m0_grant = m1_grant = 0; hold counter = 0.
  - Last-served pointer = M1, so M0 wins the first tie.
  - All s_* outputs and m_din = 0.
- States: IDLE, OWN0, OWN1. Grants are registered: m0_grant = (state==OWN0), m1_grant = (state==OWN1), never both 1.
- IDLE transitions:
  - Only m0_req -> OWN0. Only m1_req -> OWN1.
  - Both -> the master not equal to the last-served pointer.
  - Neither -> stay IDLE.
  - Grant latency is 1 cycle from request sample.
- OWNx transitions:
  - Owner req=1 and (other req=0 or counter < MAX_HOLD-1) -> stay OWNx; counter increments while the other master requests, else clears to 0.
  - Owner req=1, other req=1, counter == MAX_HOLD-1 -> forced handover: go directly to the other OWN state, counter = 0.
  - Owner req=0, other req=1 -> go directly to the other OWN state; no idle bubble.
  - Owner req=0, other req=0 -> IDLE.
- Last-served pointer: updated to x on every entry into OWNx.
- Masters must tolerate grant removal at any cycle: a master stalls when its grant is low and re-requests.
- Datapath (combinational from state and owner inputs):
  - Owner inputs drive s_wr/s_addr/s_din. In IDLE these drive 0.
  - s0_sel = owner active & s_addr[15:12]==4'h0.
  - s1_sel = owner active & s_addr[15:12]==4'h1.
  - Other address ranges select nothing. Writes there are dropped; reads return 0.
- Read data: m_din = s0_dout if s0_sel, s1_dout if s1_sel, else 0. Same-cycle path, no pipelining; slaves return read data combinationally or registered as their own spec states.
- Simultaneous events:
  - Owner drop coincident with other request follows the direct-switch rule.
  - A request edge on the same cycle as reset deassertion is sampled on the first clk edge after deassertion.
- Reset mid-operation: grants drop immediately (asynchronously); the s_* mux returns to 0 in the same cycle.

Test Plan:
- Reset with m0_req=m1_req=1 -> grants 0 during reset; 1 cycle after release m0_grant=1, m1_grant=0.
- m1_req only; m1_addr=16'h1004, m1_wr=1, m1_dout=32'hDEADBEEF -> next cycle m1_grant=1, s1_sel=1, s0_sel=0, s_addr=16'h1004, s_wr=1, s_din=32'hDEADBEEF.
- M0 owns and reads 16'h0008 with s0_dout=32'h00000003 -> m_din=32'h00000003. Read of 16'h2000 -> no select, m_din=0.
- M0 holds req, m1_req=1 continuously, MAX_HOLD=16 -> m0_grant high exactly 16 cycles after m1_req rises, then m1_grant=1 the next cycle; round-robin alternation continues every 16 cycles.
- M0 drops req while m1_req=1 -> m1_grant=1 on the very next cycle with no IDLE cycle. Both then drop -> both grants 0 the next cycle.
- Assert reset mid-transfer while OWN1 -> m1_grant, s1_sel and s_wr go 0 before the next clk edge. After release with both requesting, M0 is granted (pointer reset to M1).

Source files
------------

// File: rtl/dmac_bus_arbiter_if.sv
// Shared-bus bundle between the two DMAC-side masters, the arbiter and the two slaves.
// Latency: none (wires only).
// Backpressure: none here; ownership is signalled by the registered grants.
// Signals:
//   m0_*/m1_*   request, write strobe, address, write data in; grant out
//   m_din       read data returned to both masters
//   s0/s1_sel   slave selects; s_wr/s_addr/s_din carry the owner's cycle
//   s0/s1_dout  slave read data
// Modports:
//   slave  - the arbiter's view (consumes requests, produces grants and slave-side bus)
//   master - the surrounding system's view (masters and slaves)
interface dmac_bus_arbiter_if;
   logic        m0_req;
   logic        m0_wr;
   logic [15:0] m0_addr;
   logic [31:0] m0_dout;
   logic        m0_grant;
   logic        m1_req;
   logic        m1_wr;
   logic [15:0] m1_addr;
   logic [31:0] m1_dout;
   logic        m1_grant;
   logic [31:0] m_din;
   logic        s0_sel;
   logic        s1_sel;
   logic        s_wr;
   logic [15:0] s_addr;
   logic [31:0] s_din;
   logic [31:0] s0_dout;
   logic [31:0] s1_dout;

   modport slave (
      input  m0_req, m0_wr, m0_addr, m0_dout,
      input  m1_req, m1_wr, m1_addr, m1_dout,
      input  s0_dout, s1_dout,
      output m0_grant, m1_grant, m_din,
      output s0_sel, s1_sel, s_wr, s_addr, s_din
   );

   modport master (
      output m0_req, m0_wr, m0_addr, m0_dout,
      output m1_req, m1_wr, m1_addr, m1_dout,
      output s0_dout, s1_dout,
      input  m0_grant, m1_grant, m_din,
      input  s0_sel, s1_sel, s_wr, s_addr, s_din
   );
endinterface

// File: rtl/dmac_bus_arbiter.sv
// Round-robin two-master / two-slave bus arbiter with starvation limit and address decode.
// Latency: grant 1 cycle after request is sampled; datapath mux and read return are same-cycle.
// Backpressure: a master without grant must stall; grant may be withdrawn on any cycle.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - dmac_bus_arbiter_if.slave: master requests/grants, slave-side mux, read return
// Parameters: MAX_HOLD (>= 2) consecutive contended cycles per owner; CNT_W with 2**CNT_W > MAX_HOLD.
module dmac_bus_arbiter #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input logic               clk,
   input logic               reset,
   dmac_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Last-served master: 0 = M0, 1 = M1. Resets to M1 so M0 wins the first tie.
   logic             last_q, last_d;

   // Owner/other view lets OWN0 and OWN1 share one transition rule.
   logic   own_req, oth_req;
   state_t oth_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      own_req   = 1'b0;
      oth_req   = 1'b0;
      oth_state = ST_IDLE;

      case (state_q)
         ST_OWN0: begin
            own_req   = bus.m0_req;
            oth_req   = bus.m1_req;
            oth_state = ST_OWN1;
         end
         ST_OWN1: begin
            own_req   = bus.m1_req;
            oth_req   = bus.m0_req;
            oth_state = ST_OWN0;
         end
         default: ;
      endcase

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.m0_req && bus.m1_req) begin
               state_d = last_q ? ST_OWN0 : ST_OWN1;
            end else if (bus.m0_req) begin
               state_d = ST_OWN0;
            end else if (bus.m1_req) begin
               state_d = ST_OWN1;
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (own_req) begin
               if (!oth_req) begin
                  // Uncontended: the hold budget only runs while someone is waiting.
                  cnt_d = '0;
               end else if (cnt_q == HOLD_LAST) begin
                  state_d = oth_state;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               // Owner released: hand straight over if the other master waits, no idle bubble.
               state_d = oth_req ? oth_state : ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (state_d == ST_OWN0) begin
         last_d = 1'b0;
      end else if (state_d == ST_OWN1) begin
         last_d = 1'b1;
      end
   end

   // Datapath is driven from the registered state so an asynchronous reset
   // clears grants, selects and the slave-side mux immediately.
   always_comb begin
      bus.m0_grant = (state_q == ST_OWN0);
      bus.m1_grant = (state_q == ST_OWN1);
      bus.s_wr     = 1'b0;
      bus.s_addr   = '0;
      bus.s_din    = '0;
      bus.s0_sel   = 1'b0;
      bus.s1_sel   = 1'b0;
      bus.m_din    = '0;

      if (state_q == ST_OWN0) begin
         bus.s_wr   = bus.m0_wr;
         bus.s_addr = bus.m0_addr;
         bus.s_din  = bus.m0_dout;
      end else if (state_q == ST_OWN1) begin
         bus.s_wr   = bus.m1_wr;
         bus.s_addr = bus.m1_addr;
         bus.s_din  = bus.m1_dout;
      end

      // Only 4 KB windows 0x0xxx and 0x1xxx are populated; anything else is a
      // dropped write / zero read.
      if (state_q != ST_IDLE) begin
         bus.s0_sel = (bus.s_addr[15:12] == 4'h0);
         bus.s1_sel = (bus.s_addr[15:12] == 4'h1);
      end

      if (bus.s0_sel) begin
         bus.m_din = bus.s0_dout;
      end else if (bus.s1_sel) begin
         bus.m_din = bus.s1_dout;
      end
   end

endmodule

// File: tb/tb_dmac_bus_arbiter.sv
// Directed bench for dmac_bus_arbiter: reset, decode/mux, round-robin, starvation, handover.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: masters modelled as simple request drivers.
module tb_dmac_bus_arbiter;

   logic clk;
   logic reset;
   int   errs;
   int   checks;

   dmac_bus_arbiter_if bus ();

   dmac_bus_arbiter #(
      .MAX_HOLD(16),
      .CNT_W   (5)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_all();
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      bus.m0_wr  = 1'b0;
      bus.m1_wr  = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.m0_req  = 1'b1;
      bus.m1_req  = 1'b1;
      bus.m0_wr   = 1'b1;
      bus.m0_addr = 16'h0004;
      bus.s0_dout = 32'h1111_2222;
      tick();
      tick();
      checks++;
      if (bus.m0_grant !== 1'b0 || bus.m1_grant !== 1'b0) begin
         errs++;
         $display("FAIL reset_grants: got m0=%b m1=%b, want 0 0", bus.m0_grant, bus.m1_grant);
      end
      checks++;
      if (bus.s0_sel !== 1'b0 || bus.s_wr !== 1'b0 || bus.s_addr !== 16'h0 || bus.m_din !== 32'h0) begin
         errs++;
         $display("FAIL reset_bus: got s0_sel=%b s_wr=%b s_addr=%h m_din=%h, want all 0",
                  bus.s0_sel, bus.s_wr, bus.s_addr, bus.m_din);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.m0_grant !== 1'b1 || bus.m1_grant !== 1'b0) begin
         errs++;
         $display("FAIL reset_first_tie: got m0=%b m1=%b, want 1 0", bus.m0_grant, bus.m1_grant);
      end
      drop_all();
      checks++;
      if (bus.m0_grant !== 1'b0 || bus.m1_grant !== 1'b0) begin
         errs++;
         $display("FAIL reset_idle: got m0=%b m1=%b, want 0 0", bus.m0_grant, bus.m1_grant);
      end
   endtask

   task automatic test_m1_write();
      bus.m1_req  = 1'b1;
      bus.m1_wr   = 1'b1;
      bus.m1_addr = 16'h1004;
      bus.m1_dout = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (bus.m1_grant !== 1'b1 || bus.m0_grant !== 1'b0) begin
         errs++;
         $display("FAIL m1w_grant: got m0=%b m1=%b, want 0 1", bus.m0_grant, bus.m1_grant);
      end
      checks++;
      if (bus.s1_sel !== 1'b1 || bus.s0_sel !== 1'b0) begin
         errs++;
         $display("FAIL m1w_sel: got s0=%b s1=%b, want 0 1", bus.s0_sel, bus.s1_sel);
      end
      checks++;
      if (bus.s_addr !== 16'h1004 || bus.s_wr !== 1'b1 || bus.s_din !== 32'hDEAD_BEEF) begin
         errs++;
         $display("FAIL m1w_bus: got addr=%h wr=%b din=%h, want 1004 1 deadbeef",
                  bus.s_addr, bus.s_wr, bus.s_din);
      end
      drop_all();
      checks++;
      if (bus.m1_grant !== 1'b0 || bus.s_addr !== 16'h0 || bus.s_din !== 32'h0 || bus.s1_sel !== 1'b0) begin
         errs++;
         $display("FAIL m1w_idle: got grant=%b addr=%h din=%h s1=%b, want 0 0 0 0",
                  bus.m1_grant, bus.s_addr, bus.s_din, bus.s1_sel);
      end
   endtask

   task automatic test_m0_read();
      bus.m0_req  = 1'b1;
      bus.m0_wr   = 1'b0;
      bus.m0_addr = 16'h0008;
      bus.s0_dout = 32'h0000_0003;
      bus.s1_dout = 32'h0000_0055;
      tick();
      checks++;
      if (bus.m0_grant !== 1'b1 || bus.s0_sel !== 1'b1 || bus.m_din !== 32'h0000_0003) begin
         errs++;
         $display("FAIL m0r_s0: got grant=%b s0=%b m_din=%h, want 1 1 00000003",
                  bus.m0_grant, bus.s0_sel, bus.m_din);
      end
      bus.m0_addr = 16'h1010;
      #1;
      checks++;
      if (bus.s1_sel !== 1'b1 || bus.s0_sel !== 1'b0 || bus.m_din !== 32'h0000_0055) begin
         errs++;
         $display("FAIL m0r_s1: got s0=%b s1=%b m_din=%h, want 0 1 00000055",
                  bus.s0_sel, bus.s1_sel, bus.m_din);
      end
      bus.m0_addr = 16'h2000;
      #1;
      checks++;
      if (bus.s0_sel !== 1'b0 || bus.s1_sel !== 1'b0 || bus.m_din !== 32'h0) begin
         errs++;
         $display("FAIL m0r_unmapped: got s0=%b s1=%b m_din=%h, want 0 0 0",
                  bus.s0_sel, bus.s1_sel, bus.m_din);
      end
      drop_all();
   endtask

   // Last served was M0, so a tie from IDLE goes to M1.
   task automatic test_round_robin_tie();
      bus.m0_req = 1'b1;
      bus.m1_req = 1'b1;
      tick();
      checks++;
      if (bus.m1_grant !== 1'b1 || bus.m0_grant !== 1'b0) begin
         errs++;
         $display("FAIL rr_tie: got m0=%b m1=%b, want 0 1", bus.m0_grant, bus.m1_grant);
      end
      drop_all();
   endtask

   // A gap in M1's request clears the hold counter, so M0 gets a full budget again.
   task automatic test_hold_clear();
      int bad;
      bad = 0;
      bus.m0_req = 1'b1;
      tick();
      bus.m1_req = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      bus.m1_req = 1'b0;
      tick();
      bus.m1_req = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.m0_grant !== 1'b1 || bus.m1_grant !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errs++;
         $display("FAIL hold_clear_keep: got %0d cycles without m0 grant, want 0", bad);
      end
      tick();
      checks++;
      if (bus.m1_grant !== 1'b1 || bus.m0_grant !== 1'b0) begin
         errs++;
         $display("FAIL hold_clear_switch: got m0=%b m1=%b, want 0 1", bus.m0_grant, bus.m1_grant);
      end
      drop_all();
   endtask

   task automatic test_starvation();
      int bad0, bad1;
      bad0 = 0;
      bad1 = 0;
      bus.m0_req = 1'b1;
      tick();
      bus.m1_req = 1'b1;
      // Cycle in which m1_req rose counts as the first of 16 contended cycles.
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.m0_grant !== 1'b1 || bus.m1_grant !== 1'b0) bad0++;
      end
      checks++;
      if (bad0 !== 0) begin
         errs++;
         $display("FAIL starve_m0_hold: got %0d short cycles, want 0", bad0);
      end
      tick();
      checks++;
      if (bus.m1_grant !== 1'b1 || bus.m0_grant !== 1'b0) begin
         errs++;
         $display("FAIL starve_to_m1: got m0=%b m1=%b, want 0 1", bus.m0_grant, bus.m1_grant);
      end
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.m1_grant !== 1'b1 || bus.m0_grant !== 1'b0) bad1++;
      end
      checks++;
      if (bad1 !== 0) begin
         errs++;
         $display("FAIL starve_m1_hold: got %0d short cycles, want 0", bad1);
      end
      tick();
      checks++;
      if (bus.m0_grant !== 1'b1 || bus.m1_grant !== 1'b0) begin
         errs++;
         $display("FAIL starve_to_m0: got m0=%b m1=%b, want 1 0", bus.m0_grant, bus.m1_grant);
      end
   endtask

   // Entered with M0 owning and both requesting.
   task automatic test_direct_switch();
      bus.m0_req = 1'b0;
      tick();
      checks++;
      if (bus.m1_grant !== 1'b1 || bus.m0_grant !== 1'b0) begin
         errs++;
         $display("FAIL switch_no_bubble: got m0=%b m1=%b, want 0 1", bus.m0_grant, bus.m1_grant);
      end
      bus.m1_req = 1'b0;
      tick();
      checks++;
      if (bus.m1_grant !== 1'b0 || bus.m0_grant !== 1'b0) begin
         errs++;
         $display("FAIL switch_both_drop: got m0=%b m1=%b, want 0 0", bus.m0_grant, bus.m1_grant);
      end
   endtask

   task automatic test_reset_mid();
      bus.m1_req  = 1'b1;
      bus.m1_wr   = 1'b1;
      bus.m1_addr = 16'h1000;
      tick();
      checks++;
      if (bus.m1_grant !== 1'b1 || bus.s1_sel !== 1'b1 || bus.s_wr !== 1'b1) begin
         errs++;
         $display("FAIL mid_pre: got grant=%b s1=%b wr=%b, want 1 1 1", bus.m1_grant, bus.s1_sel, bus.s_wr);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.m1_grant !== 1'b0 || bus.s1_sel !== 1'b0 || bus.s_wr !== 1'b0) begin
         errs++;
         $display("FAIL mid_async: got grant=%b s1=%b wr=%b, want 0 0 0", bus.m1_grant, bus.s1_sel, bus.s_wr);
      end
      bus.m0_req = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (bus.m0_grant !== 1'b1 || bus.m1_grant !== 1'b0) begin
         errs++;
         $display("FAIL mid_after: got m0=%b m1=%b, want 1 0", bus.m0_grant, bus.m1_grant);
      end
      drop_all();
   endtask

   initial begin
      errs        = 0;
      checks      = 0;
      reset       = 1'b1;
      bus.m0_req  = 1'b0;
      bus.m0_wr   = 1'b0;
      bus.m0_addr = '0;
      bus.m0_dout = '0;
      bus.m1_req  = 1'b0;
      bus.m1_wr   = 1'b0;
      bus.m1_addr = '0;
      bus.m1_dout = '0;
      bus.s0_dout = '0;
      bus.s1_dout = '0;

      test_reset();
      test_m1_write();
      test_m0_read();
      test_round_robin_tie();
      test_hold_clear();
      test_starvation();
      test_direct_switch();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
